sio_bus_master: RTL and testbench

// - Bus initiator for the 4-bit-address simpleio register bus (AD/DI/DO/rw/cs); CPU-less host for the IO block.
// - Accepts read/write commands on a valid/ready port, runs exactly one cs cycle per access, returns read data/ack.
// - Optional IRQ service: on a rising irq, auto-reads a status register (read clears timer IRQ) and tags the reply.
// - Used by debug bridges and the standalone test harness; sits between the command source and simpleio.

---
 rtl/sio_bus_pkg.sv | 28 ++
 rtl/sio_irq_sync.sv | 41 ++++
 rtl/sio_bus_master.sv | 146 ++++++++++++++
 tb/tb_sio_bus_master.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_bus_pkg.sv
// Shared types and register map for the simpleio bus master.
// No ports; imported by sio_irq_sync and sio_bus_master.
// Holds the master FSM state type and the slave register address constants.
package sio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // simpleio register map
  localparam logic [3:0] ADDR_LEDS     = 4'h0;
  localparam logic [3:0] ADDR_SEG_HI   = 4'h1;
  localparam logic [3:0] ADDR_SEG_LO   = 4'h2;
  localparam logic [3:0] ADDR_RGB      = 4'h3;
  localparam logic [3:0] ADDR_KEYS     = 4'h4;
  localparam logic [3:0] ADDR_TMR_MODE = 4'h8;
  localparam logic [3:0] ADDR_TMR_PRE0 = 4'h9;
  localparam logic [3:0] ADDR_TMR_PRE1 = 4'hA;
  localparam logic [3:0] ADDR_TMR_PRE2 = 4'hB;
  localparam logic [3:0] ADDR_CLK_MODE = 4'hC;
  localparam logic [3:0] ADDR_CLK_PRE0 = 4'hD;
  localparam logic [3:0] ADDR_CLK_PRE1 = 4'hE;
  localparam logic [3:0] ADDR_CLK_PRE2 = 4'hF;

endpackage

// File: rtl/sio_irq_sync.sv
// Purpose: 2-flop synchroniser for the async slave irq plus rising-edge detector.
// Latency: irq_level follows irq_async after 2 clocks; irq_rise pulses 1 cycle on the 3rd.
// Backpressure: none; irq_rise is a single-cycle pulse the consumer must latch.
// Ports: clk_in/rst (sync, active-high), irq_async in, irq_level/irq_rise out.
module sio_irq_sync
  import sio_bus_pkg::*;
(
  input  logic clk_in,
  input  logic rst,
  input  logic irq_async,
  output logic irq_level,
  output logic irq_rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = irq_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign irq_level = sync2_q;
  // A held-high level produces exactly one pulse.
  assign irq_rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/sio_bus_master.sv
// Purpose: simpleio bus initiator; one cs cycle per command, optional irq status auto-read.
// Latency: write ack 2 cycles after accept, read 2+READ_LAT cycles after accept.
// Backpressure: response held until rsp_ready; cmd_ready low whenever not idle or irq pending.
// Ports: cmd_* command in (valid/ready), rsp_* response out (valid/ready),
//        bus_* to/from the simpleio slave, irq async in, irq_pending synchronised level out.
module sio_bus_master
  import sio_bus_pkg::*;
#(
  parameter int         READ_LAT = 1,
  parameter logic [3:0] IRQ_ADDR = ADDR_TMR_MODE,
  parameter bit         AUTO_IRQ = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_write,
  output logic       rsp_irq,
  output logic [3:0] bus_ad,
  output logic [7:0] bus_do,
  input  logic [7:0] bus_di,
  output logic       bus_rw,
  output logic       bus_cs,
  input  logic       irq,
  output logic       irq_pending
);

  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] ad_q, ad_d;
  logic [7:0] do_q, do_d;
  logic       rw_q, rw_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       write_q, write_d;
  logic       tag_irq_q, tag_irq_d;
  logic       irq_req_q, irq_req_d;
  logic       irq_rise;

  sio_irq_sync u_irq_sync (
    .clk_in    (clk_in),
    .rst       (rst),
    .irq_async (irq),
    .irq_level (irq_pending),
    .irq_rise  (irq_rise)
  );

  always_comb begin
    state_d   = state_q;
    ad_d      = ad_q;
    do_d      = do_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    tag_irq_d = tag_irq_q;
    irq_req_d = irq_req_q | irq_rise;

    unique case (state_q)
      ST_IDLE: begin
        // A pending irq beats any command offered in the same cycle.
        if (AUTO_IRQ && irq_req_q) begin
          state_d   = ST_ACCESS;
          ad_d      = IRQ_ADDR;
          rw_d      = 1'b1;
          rdata_d   = 8'h00;
          write_d   = 1'b0;
          tag_irq_d = 1'b1;
          irq_req_d = irq_rise;
        end else if (cmd_valid) begin
          state_d   = ST_ACCESS;
          ad_d      = cmd_addr;
          do_d      = cmd_wdata;
          rw_d      = cmd_rw;
          rdata_d   = 8'h00;
          write_d   = ~cmd_rw;
          tag_irq_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        // rw parks high so the slave never sees a stray write strobe.
        rw_d = 1'b1;
        if (write_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = bus_di;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ad_q      <= 4'h0;
      do_q      <= 8'h00;
      rw_q      <= 1'b1;
      cnt_q     <= 3'd0;
      rdata_q   <= 8'h00;
      write_q   <= 1'b0;
      tag_irq_q <= 1'b0;
      irq_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ad_q      <= ad_d;
      do_q      <= do_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
      tag_irq_q <= tag_irq_d;
      irq_req_q <= irq_req_d;
    end
  end

  assign cmd_ready = ~rst & (state_q == ST_IDLE) & (~irq_req_q | ~AUTO_IRQ);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_write = write_q;
  assign rsp_irq   = tag_irq_q;
  assign bus_cs    = (state_q == ST_ACCESS);
  assign bus_ad    = ad_q;
  assign bus_do    = do_q;
  assign bus_rw    = rw_q;

endmodule

// File: tb/tb_sio_bus_master.sv
// Bench for sio_bus_master: two instances (READ_LAT=1 and READ_LAT=3) on simpleio slave models.
// Expected responses come from a shadow register map updated as commands are issued.
// The slave model only presents correct read data on the cycle READ_LAT after it samples cs.
module tb_sio_bus_master;
  import sio_bus_pkg::*;

  logic clk_in = 1'b0;
  logic rst;
  logic slv_init;

  logic [1:0] cmd_valid, cmd_rw, rsp_ready, irq;
  logic [3:0] cmd_addr [2];
  logic [7:0] cmd_wdata [2];
  logic [7:0] bus_di [2];
  wire  [1:0] cmd_ready, rsp_valid, rsp_write, rsp_irq, bus_rw, bus_cs, irq_pending;
  wire  [7:0] rsp_rdata [2];
  wire  [3:0] bus_ad [2];
  wire  [7:0] bus_do [2];

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [2][16];
  logic [7:0] rd_val [2];
  logic [3:0] lat [2];
  logic [1:0] cs_prev;
  int cs_cnt [2];
  int cs_viol [2];
  logic [7:0] shadow [2][16];

  always #5 clk_in = ~clk_in;

  function automatic int rl(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] init_val(input int a);
    return (a == 4) ? 8'hF3 : 8'(a * 29 + 65);
  endfunction

  sio_bus_master #(.READ_LAT(1)) dut0 (
    .clk_in(clk_in), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_rw(cmd_rw[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_write(rsp_write[0]), .rsp_irq(rsp_irq[0]),
    .bus_ad(bus_ad[0]), .bus_do(bus_do[0]), .bus_di(bus_di[0]),
    .bus_rw(bus_rw[0]), .bus_cs(bus_cs[0]),
    .irq(irq[0]), .irq_pending(irq_pending[0])
  );

  sio_bus_master #(.READ_LAT(3)) dut1 (
    .clk_in(clk_in), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_rw(cmd_rw[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_write(rsp_write[1]), .rsp_irq(rsp_irq[1]),
    .bus_ad(bus_ad[1]), .bus_do(bus_do[1]), .bus_di(bus_di[1]),
    .bus_rw(bus_rw[1]), .bus_cs(bus_cs[1]),
    .irq(irq[1]), .irq_pending(irq_pending[1])
  );

  // simpleio slave models: sample cs on the clock, side effects once per cs cycle.
  always @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (slv_init) begin
        for (int a = 0; a < 16; a++) mem[i][a] <= init_val(a);
        lat[i]     <= 4'd0;
        cs_prev[i] <= 1'b0;
        cs_cnt[i]  <= 0;
        cs_viol[i] <= 0;
        rd_val[i]  <= 8'h00;
      end else begin
        cs_prev[i] <= bus_cs[i];
        if (bus_cs[i]) begin
          cs_cnt[i] <= cs_cnt[i] + 1;
          if (cs_prev[i]) cs_viol[i] <= cs_viol[i] + 1;
          if (!bus_rw[i]) mem[i][bus_ad[i]] <= bus_do[i];
          else            rd_val[i] <= mem[i][bus_ad[i]];
          lat[i] <= 4'd1;
        end else if (lat[i] != 4'd0 && lat[i] != 4'd15) begin
          lat[i] <= lat[i] + 4'd1;
        end
      end
    end
  end

  // Read data is only correct on the READ_LAT-th cycle; it differs on every other cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (lat[i] == 4'd0)             bus_di[i] = 8'hEE;
      else if (lat[i] == 4'(rl(i)))   bus_di[i] = rd_val[i];
      else                            bus_di[i] = rd_val[i] ^ {lat[i], 4'h5};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input int i, input logic [7:0] exp_d, input logic exp_w,
                          input logic exp_irq, input int hold);
    int k;
    k = 0;
    @(negedge clk_in);
    while (!rsp_valid[i] && k < 30) begin
      @(negedge clk_in);
      k++;
    end
    chk("rsp_timeout", 32'(k < 30), 1);
    chk("rsp_rdata", rsp_rdata[i], exp_d);
    chk("rsp_write", rsp_write[i], exp_w);
    chk("rsp_irq", rsp_irq[i], exp_irq);
    repeat (hold) begin
      @(negedge clk_in);
      chk("wait_hold_ready", cmd_ready[i], 0);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk_in);
    #1 rsp_ready[i] = 1'b0;
  endtask

  task automatic run_cmd(input int i, input logic rw, input logic [3:0] addr,
                         input logic [7:0] wdata, input int hold);
    logic [7:0] exp_d;
    int k;
    int cs0;
    exp_d = rw ? shadow[i][addr] : 8'h00;
    if (!rw) shadow[i][addr] = wdata;
    @(negedge clk_in);
    cmd_valid[i] = 1'b1;
    cmd_rw[i]    = rw;
    cmd_addr[i]  = addr;
    cmd_wdata[i] = wdata;
    k = 0;
    while (!cmd_ready[i] && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    chk("accept_timeout", 32'(k < 20), 1);
    @(posedge clk_in);
    #1 cmd_valid[i] = 1'b0;
    @(negedge clk_in);
    chk("access_cs", bus_cs[i], 1);
    chk("access_ad", bus_ad[i], addr);
    chk("access_rw", bus_rw[i], rw);
    if (!rw) chk("access_do", bus_do[i], wdata);
    k = 1;
    while (!rsp_valid[i] && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    chk("latency", k, rw ? 2 + rl(i) : 2);
    chk("rsp_rdata", rsp_rdata[i], exp_d);
    chk("rsp_write", rsp_write[i], !rw);
    chk("rsp_irq", rsp_irq[i], 0);
    chk("rsp_cs_low", bus_cs[i], 0);
    chk("rsp_rw_parked", bus_rw[i], 1);
    cs0 = cs_cnt[i];
    repeat (hold) begin
      @(negedge clk_in);
      chk("hold_valid", rsp_valid[i], 1);
      chk("hold_rdata", rsp_rdata[i], exp_d);
      chk("hold_cmd_ready", cmd_ready[i], 0);
    end
    chk("hold_no_cs", cs_cnt[i], cs0);
    rsp_ready[i] = 1'b1;
    @(posedge clk_in);
    #1 rsp_ready[i] = 1'b0;
    @(negedge clk_in);
    chk("rsp_dropped", rsp_valid[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cs0;
    rst = 1'b1;
    slv_init = 1'b1;
    cmd_valid = '0; cmd_rw = '1; rsp_ready = '0; irq = '0;
    for (int i = 0; i < 2; i++) begin
      cmd_addr[i] = 4'h0;
      cmd_wdata[i] = 8'h00;
      for (int a = 0; a < 16; a++) shadow[i][a] = init_val(a);
    end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", cmd_ready[i], 0);
      chk("rst_rsp_valid", rsp_valid[i], 0);
      chk("rst_rsp_rdata", rsp_rdata[i], 0);
      chk("rst_rsp_write", rsp_write[i], 0);
      chk("rst_rsp_irq", rsp_irq[i], 0);
      chk("rst_bus_cs", bus_cs[i], 0);
      chk("rst_bus_rw", bus_rw[i], 1);
      chk("rst_bus_ad", bus_ad[i], 0);
      chk("rst_bus_do", bus_do[i], 0);
      chk("rst_irq_pending", irq_pending[i], 0);
    end
    rst = 1'b0;
    slv_init = 1'b0;
    @(negedge clk_in);
    chk("idle_cmd_ready0", cmd_ready[0], 1);
    chk("idle_cmd_ready1", cmd_ready[1], 1);

    // Directed: write then read with long response backpressure.
    run_cmd(0, 1'b0, ADDR_LEDS, 8'h5A, 0);
    run_cmd(0, 1'b1, ADDR_KEYS, 8'h00, 10);
    chk("slave_mem_write", mem[0][0], 8'h5A);

    // READ_LAT=3 read: slave data is only right on the third cycle.
    run_cmd(1, 1'b1, ADDR_KEYS, 8'h00, 0);
    run_cmd(1, 1'b0, ADDR_RGB, 8'hC3, 1);
    run_cmd(1, 1'b1, ADDR_RGB, 8'h00, 0);

    // irq rises while busy with a read; next command already waiting when it completes.
    @(negedge clk_in);
    cmd_valid[0] = 1'b1; cmd_rw[0] = 1'b1; cmd_addr[0] = ADDR_SEG_HI; cmd_wdata[0] = 8'h00;
    k = 0;
    while (!cmd_ready[0] && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    @(posedge clk_in);
    #1;
    cmd_rw[0] = 1'b0; cmd_addr[0] = ADDR_SEG_LO; cmd_wdata[0] = 8'h77;
    irq[0] = 1'b1;
    wait_rsp(0, shadow[0][ADDR_SEG_HI], 1'b0, 1'b0, 4);
    chk("irq_pending_level", irq_pending[0], 1);
    wait_rsp(0, shadow[0][ADDR_TMR_MODE], 1'b0, 1'b1, 0);
    @(negedge clk_in);
    k = 0;
    while (!cmd_ready[0] && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    chk("post_irq_accept", 32'(k < 20), 1);
    @(posedge clk_in);
    #1 cmd_valid[0] = 1'b0;
    shadow[0][ADDR_SEG_LO] = 8'h77;
    wait_rsp(0, 8'h00, 1'b1, 1'b0, 0);
    cs0 = cs_cnt[0];
    repeat (12) @(negedge clk_in);
    chk("irq_held_no_retrigger", cs_cnt[0], cs0);
    chk("irq_held_no_rsp", rsp_valid[0], 0);
    chk("slave_seg_lo", mem[0][ADDR_SEG_LO], 8'h77);
    irq[0] = 1'b0;
    repeat (4) @(negedge clk_in);

    // Randomized traffic on both instances.
    for (int n = 0; n < 30; n++) begin
      int i;
      logic rw;
      logic [3:0] a;
      logic [7:0] d;
      i  = int'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      run_cmd(i, rw, a, d, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a READ_LAT=3 read.
    @(negedge clk_in);
    cmd_valid[1] = 1'b1; cmd_rw[1] = 1'b1; cmd_addr[1] = ADDR_KEYS;
    k = 0;
    while (!cmd_ready[1] && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    @(posedge clk_in);
    #1 cmd_valid[1] = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    chk("midrst_cs", bus_cs[1], 0);
    chk("midrst_rsp_valid", rsp_valid[1], 0);
    chk("midrst_bus_rw", bus_rw[1], 1);
    chk("midrst_bus_ad", bus_ad[1], 0);
    rst = 1'b0;
    cs0 = cs_cnt[1];
    repeat (6) @(negedge clk_in);
    chk("midrst_no_resume_rsp", rsp_valid[1], 0);
    chk("midrst_no_resume_cs", cs_cnt[1], cs0);
    run_cmd(1, 1'b1, ADDR_KEYS, 8'h00, 0);
    run_cmd(1, 1'b0, ADDR_CLK_PRE0, 8'h3E, 0);

    chk("cs_never_consecutive", cs_viol[0] + cs_viol[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
